rename_map_ckpt: RTL and testbench



---
 rtl/rename_map_ckpt_pkg.sv | 40 ++++
 rtl/rename_map_ckpt_if.sv | 45 ++++
 rtl/rename_map_ckpt_bank.sv | 83 ++++++++
 rtl/rename_map_ckpt.sv | 154 +++++++++++++++
 tb/tb_rename_map_ckpt.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_map_ckpt_pkg.sv
// Shared types for the register alias table with branch checkpoints.
// Sizes, lane/tag bundles, map type and a pointer-wrap helper.
package rename_pkg;

   localparam int N_WAY     = 2;
   localparam int ARCH_REGS = 32;
   localparam int PHYS_REGS = 64;
   localparam int N_CKPT    = 4;

   localparam int AR_BITS  = $clog2(ARCH_REGS);
   localparam int PR_BITS  = $clog2(PHYS_REGS);
   localparam int CK_BITS  = $clog2(N_CKPT);
   localparam int CNT_BITS = CK_BITS + 1;

   typedef logic [AR_BITS-1:0]  ar_t;
   typedef logic [PR_BITS-1:0]  pr_t;
   typedef logic [CK_BITS-1:0]  ck_t;
   typedef logic [CNT_BITS-1:0] cnt_t;

   typedef logic [ARCH_REGS-1:0][PR_BITS-1:0] map_t;

   typedef struct packed {
      logic valid;
      ar_t  dest;
      ar_t  src1;
      ar_t  src2;
      logic is_br;
   } rename_lane_t;

   typedef struct packed {
      pr_t  pr;
      logic rdy;
   } src_tag_t;

   // N_CKPT is a power of two, so truncation is the modulo.
   function automatic ck_t ck_add(ck_t a, int n);
      return ck_t'(int'(a) + n);
   endfunction

endpackage

// File: rtl/rename_map_ckpt_if.sv
// Dispatch, CDB, branch-resolve and recovery bundle of the rename stage.
// master: decoder/freelist/backend side; slave: the alias table.
interface rename_map_ckpt_if;
   import rename_pkg::*;

   logic [N_WAY-1:0]              dis_valid;
   logic [N_WAY-1:0][AR_BITS-1:0] dis_dest;
   logic [N_WAY-1:0][AR_BITS-1:0] dis_src1;
   logic [N_WAY-1:0][AR_BITS-1:0] dis_src2;
   logic [N_WAY-1:0][PR_BITS-1:0] dis_new_pr;
   logic [N_WAY-1:0]              dis_is_br;
   logic [N_WAY-1:0]              cdb_valid;
   logic [N_WAY-1:0][PR_BITS-1:0] cdb_pr;
   logic                          br_valid;
   logic [CK_BITS-1:0]            br_id;
   logic                          br_mispredict;
   logic                          flush;
   map_t                          arch_map;

   logic [N_WAY-1:0][PR_BITS-1:0] src1_pr;
   logic [N_WAY-1:0][PR_BITS-1:0] src2_pr;
   logic [N_WAY-1:0]              src1_rdy;
   logic [N_WAY-1:0]              src2_rdy;
   logic [N_WAY-1:0][PR_BITS-1:0] old_pr;
   logic [CK_BITS-1:0]            ckpt_id;
   logic                          dis_stall;
   logic                          ckpt_full;

   modport master (
      output dis_valid, dis_dest, dis_src1, dis_src2,
      output dis_new_pr, dis_is_br, cdb_valid, cdb_pr,
      output br_valid, br_id, br_mispredict, flush, arch_map,
      input  src1_pr, src2_pr, src1_rdy, src2_rdy,
      input  old_pr, ckpt_id, dis_stall, ckpt_full
   );

   modport slave (
      input  dis_valid, dis_dest, dis_src1, dis_src2,
      input  dis_new_pr, dis_is_br, cdb_valid, cdb_pr,
      input  br_valid, br_id, br_mispredict, flush, arch_map,
      output src1_pr, src2_pr, src1_rdy, src2_rdy,
      output old_pr, ckpt_id, dis_stall, ckpt_full
   );

endinterface

// File: rtl/rename_map_ckpt_bank.sv
// Checkpoint slot storage with head/tail/count/done ring control.
// Ports: wr_en/wr_map snapshot at tail, br_* resolve, rd_map = slot[br_id].
module rat_ckpt_bank
   import rename_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic flush,
   input  logic wr_en,
   input  map_t wr_map,
   input  logic br_valid,
   input  logic br_mispredict,
   input  ck_t  br_id,
   output map_t rd_map,
   output ck_t  tail,
   output logic full
);

   map_t              slot_q [N_CKPT];
   ck_t               head_q;
   ck_t               tail_q;
   cnt_t              count_q;
   logic [N_CKPT-1:0] done_q;

   logic [N_CKPT-1:0] done_set;
   logic [N_CKPT-1:0] adv_mask;
   logic [N_CKPT-1:0] keep_mask;
   cnt_t              adv;
   cnt_t              keep;
   logic              run;

   // The resolve arriving this cycle already counts toward retiring
   // slots; only slots live at cycle start are considered.
   always_comb begin
      done_set = done_q;
      if (br_valid && !br_mispredict)
         done_set[br_id] = 1'b1;
      adv       = '0;
      adv_mask  = '0;
      run       = 1'b1;
      keep      = cnt_t'(ck_t'(br_id - head_q));
      keep_mask = '0;
      for (int i = 0; i < N_CKPT; i++) begin
         if (run && cnt_t'(i) < count_q &&
             done_set[ck_add(head_q, i)]) begin
            adv = adv + cnt_t'(1);
            adv_mask[ck_add(head_q, i)] = 1'b1;
         end else begin
            run = 1'b0;
         end
         if (cnt_t'(i) < keep)
            keep_mask[ck_add(head_q, i)] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         done_q  <= '0;
      end else if (br_valid && br_mispredict) begin
         tail_q  <= br_id;
         count_q <= keep;
         done_q  <= done_q & keep_mask;
      end else begin
         head_q  <= ck_add(head_q, int'(adv));
         tail_q  <= wr_en ? ck_add(tail_q, 1) : tail_q;
         count_q <= count_q - adv + cnt_t'(wr_en);
         done_q  <= done_set & ~adv_mask;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         slot_q[tail_q] <= wr_map;
   end

   assign rd_map = slot_q[br_id];
   assign tail   = tail_q;
   assign full   = (count_q == cnt_t'(N_CKPT));

endmodule

// File: rtl/rename_map_ckpt.sv
// N-way register alias table with CDB readiness and branch checkpoints.
// Ports: clock, reset (sync, high), rif (slave side of rename_map_ckpt_if).
module rename_map_ckpt
   import rename_pkg::*;
(
   input logic              clock,
   input logic              reset,
   rename_map_ckpt_if.slave rif
);

   rename_lane_t [N_WAY-1:0] lane;
   src_tag_t     [N_WAY-1:0] tag1;
   src_tag_t     [N_WAY-1:0] tag2;
   pr_t          [N_WAY-1:0] old;

   map_t                 map_q;
   map_t                 map_post;
   map_t                 ckpt_map;
   logic [PHYS_REGS-1:0] rdy_q;
   logic [PHYS_REGS-1:0] rdy_next;
   logic [PHYS_REGS-1:0] cdb_hit;

   logic has_br;
   logic mispredict;
   logic stall;
   logic accept;
   logic ck_wr;
   logic ckpt_full;
   ck_t  tail;

   always_comb begin
      for (int n = 0; n < N_WAY; n++) begin
         lane[n].valid = rif.dis_valid[n];
         lane[n].dest  = rif.dis_dest[n];
         lane[n].src1  = rif.dis_src1[n];
         lane[n].src2  = rif.dis_src2[n];
         lane[n].is_br = rif.dis_is_br[n];
      end
   end

   always_comb begin
      cdb_hit = '0;
      for (int j = 0; j < N_WAY; j++)
         if (rif.cdb_valid[j])
            cdb_hit[rif.cdb_pr[j]] = 1'b1;
   end

   // Older lanes of the bundle override the table; the youngest
   // matching older lane is applied last and therefore wins.
   always_comb begin
      for (int n = 0; n < N_WAY; n++) begin
         tag1[n].pr  = map_q[lane[n].src1];
         tag1[n].rdy = rdy_q[tag1[n].pr] | cdb_hit[tag1[n].pr];
         tag2[n].pr  = map_q[lane[n].src2];
         tag2[n].rdy = rdy_q[tag2[n].pr] | cdb_hit[tag2[n].pr];
         old[n]      = map_q[lane[n].dest];
         for (int k = 0; k < n; k++) begin
            if (lane[k].valid && lane[k].dest != '0) begin
               if (lane[k].dest == lane[n].src1)
                  tag1[n] = '{pr: rif.dis_new_pr[k], rdy: 1'b0};
               if (lane[k].dest == lane[n].src2)
                  tag2[n] = '{pr: rif.dis_new_pr[k], rdy: 1'b0};
               if (lane[k].dest == lane[n].dest)
                  old[n] = rif.dis_new_pr[k];
            end
         end
         if (lane[n].src1 == '0)
            tag1[n] = '{pr: '0, rdy: 1'b1};
         if (lane[n].src2 == '0)
            tag2[n] = '{pr: '0, rdy: 1'b1};
         if (lane[n].dest == '0)
            old[n] = '0;
         if (!lane[n].valid) begin
            tag1[n] = '0;
            tag2[n] = '0;
            old[n]  = '0;
         end
      end
   end

   always_comb begin
      has_br = 1'b0;
      for (int n = 0; n < N_WAY; n++)
         has_br = has_br | (lane[n].valid & lane[n].is_br);
   end

   // ckpt_full reflects the count at cycle start, so a same-cycle
   // correct resolve never frees room for this bundle.
   assign mispredict = rif.br_valid & rif.br_mispredict;
   assign stall      = ckpt_full & has_br;
   assign accept     = ~stall & ~rif.flush & ~mispredict;
   assign ck_wr      = accept & has_br;

   always_comb begin
      map_post = map_q;
      for (int n = 0; n < N_WAY; n++)
         if (lane[n].valid && lane[n].dest != '0)
            map_post[lane[n].dest] = rif.dis_new_pr[n];
   end

   // Allocation clears are applied after CDB sets so the clear wins.
   always_comb begin
      rdy_next = rdy_q | cdb_hit;
      if (accept)
         for (int n = 0; n < N_WAY; n++)
            if (lane[n].valid && lane[n].dest != '0)
               rdy_next[rif.dis_new_pr[n]] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++)
            map_q[i] <= PR_BITS'(i);
         rdy_q <= '1;
      end else if (rif.flush) begin
         map_q <= rif.arch_map;
         rdy_q <= '1;
      end else begin
         if (mispredict)
            map_q <= ckpt_map;
         else if (accept)
            map_q <= map_post;
         rdy_q <= rdy_next;
      end
   end

   rat_ckpt_bank u_bank (
      .clock         (clock),
      .reset         (reset),
      .flush         (rif.flush),
      .wr_en         (ck_wr),
      .wr_map        (map_post),
      .br_valid      (rif.br_valid),
      .br_mispredict (rif.br_mispredict),
      .br_id         (rif.br_id),
      .rd_map        (ckpt_map),
      .tail          (tail),
      .full          (ckpt_full)
   );

   always_comb begin
      for (int n = 0; n < N_WAY; n++) begin
         rif.src1_pr[n]  = tag1[n].pr;
         rif.src1_rdy[n] = tag1[n].rdy;
         rif.src2_pr[n]  = tag2[n].pr;
         rif.src2_rdy[n] = tag2[n].rdy;
         rif.old_pr[n]   = old[n];
      end
      rif.ckpt_id   = has_br ? tail : '0;
      rif.dis_stall = stall;
      rif.ckpt_full = ckpt_full;
   end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Bench for rename_map_ckpt: directed vector table, then random
// stimulus against a queue-based reference model of the alias table.
module tb_rename_map_ckpt;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   rename_map_ckpt_if rif ();

   rename_map_ckpt dut (
      .clock (clock),
      .reset (reset),
      .rif   (rif.slave)
   );

   int n_err = 0;
   int n_chk = 0;

   int ex_pr[2], ex_rdy[2], ey_pr[2], ey_rdy[2], eo[2];
   int eck, est, efu;

   typedef struct {
      int v, br;
      int d0, a0, b0, p0;
      int d1, a1, b1, p1;
      int cp, bid, bm, fl;
      int x0, xr0, y0, yr0, o0;
      int x1, xr1, y1, yr1, o1;
      int ck, st, fu;
   } vec_t;

   vec_t vt[22];

   typedef struct packed {
      logic [1:0]       id;
      logic             done;
      logic [31:0][5:0] m;
   } ck_e;

   int  m_map[32];
   bit  m_rdy[64];
   ck_e m_q[$];
   int  m_tail;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic compare(string tag);
      for (int n = 0; n < 2; n++) begin
         chk($sformatf("%s src1_pr[%0d]", tag, n),
             int'(rif.src1_pr[n]), ex_pr[n]);
         chk($sformatf("%s src1_rdy[%0d]", tag, n),
             int'(rif.src1_rdy[n]), ex_rdy[n]);
         chk($sformatf("%s src2_pr[%0d]", tag, n),
             int'(rif.src2_pr[n]), ey_pr[n]);
         chk($sformatf("%s src2_rdy[%0d]", tag, n),
             int'(rif.src2_rdy[n]), ey_rdy[n]);
         chk($sformatf("%s old_pr[%0d]", tag, n),
             int'(rif.old_pr[n]), eo[n]);
      end
      chk({tag, " ckpt_id"}, int'(rif.ckpt_id), eck);
      chk({tag, " dis_stall"}, int'(rif.dis_stall), est);
      chk({tag, " ckpt_full"}, int'(rif.ckpt_full), efu);
   endtask

   task automatic idle();
      rif.dis_valid     = '0;
      rif.dis_dest      = '0;
      rif.dis_src1      = '0;
      rif.dis_src2      = '0;
      rif.dis_new_pr    = '0;
      rif.dis_is_br     = '0;
      rif.cdb_valid     = '0;
      rif.cdb_pr        = '0;
      rif.br_valid      = 1'b0;
      rif.br_id         = '0;
      rif.br_mispredict = 1'b0;
      rif.flush         = 1'b0;
   endtask

   task automatic drive_vec(vec_t r);
      idle();
      rif.dis_valid     = 2'(r.v);
      rif.dis_is_br     = 2'(r.br);
      rif.dis_dest[0]   = 5'(r.d0);
      rif.dis_src1[0]   = 5'(r.a0);
      rif.dis_src2[0]   = 5'(r.b0);
      rif.dis_new_pr[0] = 6'(r.p0);
      rif.dis_dest[1]   = 5'(r.d1);
      rif.dis_src1[1]   = 5'(r.a1);
      rif.dis_src2[1]   = 5'(r.b1);
      rif.dis_new_pr[1] = 6'(r.p1);
      rif.cdb_valid[0]  = (r.cp >= 0);
      rif.cdb_pr[0]     = 6'((r.cp >= 0) ? r.cp : 0);
      rif.br_valid      = (r.bid >= 0);
      rif.br_id         = 2'((r.bid >= 0) ? r.bid : 0);
      rif.br_mispredict = 1'(r.bm);
      rif.flush         = 1'(r.fl);
      ex_pr[0] = r.x0; ex_rdy[0] = r.xr0;
      ey_pr[0] = r.y0; ey_rdy[0] = r.yr0; eo[0] = r.o0;
      ex_pr[1] = r.x1; ex_rdy[1] = r.xr1;
      ey_pr[1] = r.y1; ey_rdy[1] = r.yr1; eo[1] = r.o1;
      eck = r.ck; est = r.st; efu = r.fu;
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_map[i] = i;
      for (int i = 0; i < 64; i++) m_rdy[i] = 1'b1;
      m_q.delete();
      m_tail = 0;
   endtask

   function automatic bit cdb_has(int pr);
      bit h = 1'b0;
      for (int j = 0; j < 2; j++)
         if (rif.cdb_valid[j] && int'(rif.cdb_pr[j]) == pr) h = 1'b1;
      return h;
   endfunction

   function automatic bit bundle_has_br();
      bit h = 1'b0;
      for (int n = 0; n < 2; n++)
         if (rif.dis_valid[n] && rif.dis_is_br[n]) h = 1'b1;
      return h;
   endfunction

   task automatic src_look(input int n, input int s,
                           output int pr, output int r);
      if (s == 0) begin
         pr = 0;
         r  = 1;
      end else begin
         pr = m_map[s];
         r  = int'(m_rdy[pr] || cdb_has(pr));
         for (int k = 0; k < n; k++)
            if (rif.dis_valid[k] && int'(rif.dis_dest[k]) == s) begin
               pr = int'(rif.dis_new_pr[k]);
               r  = 0;
            end
      end
   endtask

   task automatic model_predict();
      bit hb = bundle_has_br();
      efu = int'(m_q.size() == 4);
      est = int'(efu == 1 && hb);
      eck = hb ? m_tail : 0;
      for (int n = 0; n < 2; n++) begin
         int d = int'(rif.dis_dest[n]);
         if (!rif.dis_valid[n]) begin
            ex_pr[n] = 0; ex_rdy[n] = 0;
            ey_pr[n] = 0; ey_rdy[n] = 0; eo[n] = 0;
         end else begin
            src_look(n, int'(rif.dis_src1[n]), ex_pr[n], ex_rdy[n]);
            src_look(n, int'(rif.dis_src2[n]), ey_pr[n], ey_rdy[n]);
            if (d == 0) begin
               eo[n] = 0;
            end else begin
               eo[n] = m_map[d];
               for (int k = 0; k < n; k++)
                  if (rif.dis_valid[k] && int'(rif.dis_dest[k]) == d)
                     eo[n] = int'(rif.dis_new_pr[k]);
            end
         end
      end
   endtask

   task automatic model_update();
      bit hb = bundle_has_br();
      bit st = (m_q.size() == 4) && hb;
      int bid = int'(rif.br_id);
      if (reset) begin
         model_reset();
      end else if (rif.flush) begin
         for (int i = 0; i < 32; i++) m_map[i] = int'(rif.arch_map[i]);
         for (int i = 0; i < 64; i++) m_rdy[i] = 1'b1;
         m_q.delete();
         m_tail = 0;
      end else begin
         for (int j = 0; j < 2; j++)
            if (rif.cdb_valid[j]) m_rdy[int'(rif.cdb_pr[j])] = 1'b1;
         if (rif.br_valid && rif.br_mispredict) begin
            int idx = -1;
            for (int j = 0; j < m_q.size(); j++)
               if (int'(m_q[j].id) == bid) idx = j;
            if (idx >= 0) begin
               for (int i = 0; i < 32; i++) m_map[i] = int'(m_q[idx].m[i]);
               while (m_q.size() > idx) void'(m_q.pop_back());
            end
            m_tail = bid;
         end else begin
            if (rif.br_valid) begin
               for (int j = 0; j < m_q.size(); j++)
                  if (int'(m_q[j].id) == bid) begin
                     ck_e e = m_q[j];
                     e.done = 1'b1;
                     m_q[j] = e;
                  end
               while (m_q.size() > 0 && m_q[0].done)
                  void'(m_q.pop_front());
            end
            if (!st) begin
               for (int n = 0; n < 2; n++)
                  if (rif.dis_valid[n] && rif.dis_dest[n] != 0) begin
                     m_map[int'(rif.dis_dest[n])] = int'(rif.dis_new_pr[n]);
                     m_rdy[int'(rif.dis_new_pr[n])] = 1'b0;
                  end
               if (hb) begin
                  ck_e e;
                  e.id   = 2'(m_tail);
                  e.done = 1'b0;
                  for (int i = 0; i < 32; i++) e.m[i] = 6'(m_map[i]);
                  m_q.push_back(e);
                  m_tail = (m_tail + 1) % 4;
               end
            end
         end
      end
   endtask

   task automatic gen_random();
      int hi;
      idle();
      reset = ($urandom_range(0, 199) == 0);
      rif.dis_valid = 2'($urandom_range(0, 3));
      for (int n = 0; n < 2; n++) begin
         rif.dis_dest[n] = 5'($urandom_range(0, 1) != 0 ?
                              $urandom_range(0, 7) : $urandom_range(0, 31));
         rif.dis_src1[n] = 5'($urandom_range(0, 7));
         rif.dis_src2[n] = 5'($urandom_range(0, 31));
         rif.dis_new_pr[n] = 6'($urandom_range(1, 63));
         rif.cdb_valid[n]  = 1'($urandom_range(0, 1));
         rif.cdb_pr[n]     = 6'($urandom_range(0, 63));
      end
      hi = rif.dis_valid[1] ? 1 : 0;
      if (rif.dis_valid != 0 && $urandom_range(0, 2) == 0)
         rif.dis_is_br[hi] = 1'b1;
      if (m_q.size() > 0 && $urandom_range(0, 3) == 0) begin
         int idx = $urandom_range(0, m_q.size() - 1);
         if (!m_q[idx].done) begin
            rif.br_valid      = 1'b1;
            rif.br_id         = m_q[idx].id;
            rif.br_mispredict = ($urandom_range(0, 3) == 0);
         end
      end
      rif.flush = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 32; i++)
         rif.arch_map[i] = 6'($urandom_range(0, 63));
   endtask

   initial begin
      // v br  d0 a0 b0 p0  d1 a1 b1 p1  cp bid bm fl
      //   x0 xr0 y0 yr0 o0  x1 xr1 y1 yr1 o1  ck st fu
      vt[0]  = '{1,0, 3,5,0,40, 0,0,0,0, -1,-1,0,0,
                 5,1,0,1,3, 0,0,0,0,0, 0,0,0};
      vt[1]  = '{1,0, 0,3,0,0, 0,0,0,0, -1,-1,0,0,
                 40,0,0,1,0, 0,0,0,0,0, 0,0,0};
      vt[2]  = '{3,0, 7,1,2,41, 7,7,3,42, -1,-1,0,0,
                 1,1,2,1,7, 41,0,40,0,41, 0,0,0};
      vt[3]  = '{1,0, 0,7,3,0, 0,0,0,0, 40,-1,0,0,
                 42,0,40,1,0, 0,0,0,0,0, 0,0,0};
      vt[4]  = '{1,0, 0,3,0,0, 0,0,0,0, -1,-1,0,0,
                 40,1,0,1,0, 0,0,0,0,0, 0,0,0};
      vt[5]  = '{3,2, 4,0,0,50, 0,4,0,0, -1,-1,0,0,
                 0,1,0,1,4, 50,0,0,1,0, 0,0,0};
      vt[6]  = '{1,0, 4,4,0,51, 0,0,0,0, -1,-1,0,0,
                 50,0,0,1,50, 0,0,0,0,0, 0,0,0};
      vt[7]  = '{1,0, 5,4,0,52, 0,0,0,0, -1,0,1,0,
                 51,0,0,1,5, 0,0,0,0,0, 0,0,0};
      vt[8]  = '{1,0, 0,4,5,0, 0,0,0,0, -1,-1,0,0,
                 50,0,5,1,0, 0,0,0,0,0, 0,0,0};
      for (int i = 0; i < 4; i++)
         vt[9+i] = '{1,1, 0,0,0,0, 0,0,0,0, -1,-1,0,0,
                     0,1,0,1,0, 0,0,0,0,0, i,0,0};
      vt[13] = '{1,1, 4,4,0,53, 0,0,0,0, -1,-1,0,0,
                 50,0,0,1,50, 0,0,0,0,0, 0,1,1};
      vt[14] = '{1,0, 0,4,0,0, 0,0,0,0, -1,1,0,0,
                 50,0,0,1,0, 0,0,0,0,0, 0,0,1};
      vt[15] = '{1,1, 0,0,0,0, 0,0,0,0, -1,0,0,0,
                 0,1,0,1,0, 0,0,0,0,0, 0,1,1};
      vt[16] = '{1,1, 0,0,0,0, 0,0,0,0, -1,-1,0,0,
                 0,1,0,1,0, 0,0,0,0,0, 0,0,0};
      vt[17] = '{1,1, 0,0,0,0, 0,0,0,0, -1,-1,0,0,
                 0,1,0,1,0, 0,0,0,0,0, 1,0,0};
      vt[18] = '{0,0, 0,0,0,0, 0,0,0,0, -1,-1,0,0,
                 0,0,0,0,0, 0,0,0,0,0, 0,0,1};
      vt[19] = '{1,0, 6,6,0,60, 0,0,0,0, -1,3,1,1,
                 6,1,0,1,6, 0,0,0,0,0, 0,0,1};
      vt[20] = '{3,0, 0,4,7,0, 0,3,1,0, -1,-1,0,0,
                 36,1,39,1,0, 35,1,33,1,0, 0,0,0};
      vt[21] = '{3,0, 0,0,0,0, 0,19,18,0, -1,-1,0,0,
                 0,1,0,1,0, 51,1,50,1,0, 0,0,0};

      idle();
      for (int i = 0; i < 32; i++) rif.arch_map[i] = 6'(i + 32);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drive_vec(vt[i]);
         @(negedge clock);
         compare($sformatf("vec%0d", i));
         @(posedge clock);
         #1;
      end

      idle();
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      model_reset();

      for (int c = 0; c < 1500; c++) begin
         gen_random();
         model_predict();
         @(negedge clock);
         compare($sformatf("rnd%0d", c));
         @(posedge clock);
         model_update();
         #1;
      end

      reset = 1'b0;
      idle();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
